command_encoder_tx: RTL and testbench
=====================================

Name: command_encoder_tx

Overview:
Host-side initiator for the UART command link. Takes a parallel command (read/write, 15-bit address, 32-bit data) and serialises it as a framed byte sequence, 8N1 UART, onto a single TX line. The byte format is exactly what the FPGA-side command decoder parses. Used as the stimulus/bridge block driving the board's RsRx line and in loopback tests of the command path.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 2
CMD_WRITE, 8'h00, command code for memory write
CMD_READ, 8'h01, command code for memory read

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_start  input  1  request to send one command frame; sampled only in IDLE
i_command  input  8  command code (CMD_WRITE or CMD_READ)
i_address  input  15  memory word address
i_data  input  32  write data; ignored for reads
o_serial  output  1  UART TX line, idle high
o_busy  output  1  high while a frame is being transmitted
o_done  output  1  one-cycle pulse: frame fully sent
o_error  output  1  one-cycle pulse: i_start with illegal command, nothing sent

Behaviour:
- Reset (synchronous, high): state IDLE, o_serial=1, o_busy=0, o_done=0, o_error=0, all counters 0. Applies on the next edge from any state, including mid-bit; the line returns high with no partial stop bit.
- Frame byte order, MSB byte first: [command][{1'b0,address[14:8]}][address[7:0]] and, for write only, [data[31:24]][data[23:16]][data[15:8]][data[7:0]]. Write = 7 bytes, read = 3 bytes.
- UART byte: start bit 0, data bits LSB first, one stop bit 1. Each bit held exactly CLKS_PER_BIT cycles. Bytes are sent back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
- Latching: on the edge where IDLE samples i_start=1, command/address/data are captured into a 56-bit shift buffer and byte count is set to 7 or 3. Later changes on inputs have no effect on the frame.
- Illegal command (not CMD_WRITE/CMD_READ) at i_start: o_error=1 for exactly the next cycle; stay IDLE; o_serial stays 1; o_busy stays 0.
- States:
  - IDLE: o_serial=1. On legal start, go to START.
  - START: o_serial=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, bit index 0..7, each CLKS_PER_BIT cycles, then STOP.
  - STOP: o_serial=1 for CLKS_PER_BIT cycles. Then decrement byte count. If nonzero, shift the next byte in and go to START; else go to DONE.
  - DONE: one cycle, o_done=1, o_busy=0, o_serial=1, then IDLE.
- Timing: i_start sampled at edge k drives o_busy=1 and o_serial=0 from edge k+1 onward. The frame occupies exactly N*10*CLKS_PER_BIT cycles (N = 3 or 7). The o_done cycle follows directly. Earliest next accepted i_start is in the cycle after o_done.
- o_busy is 1 in START/DATA/STOP and 0 otherwise.
- i_start while busy or in DONE is ignored; it is not queued.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary. It is cleared on entry to START.

Test Plan:
1. CLKS_PER_BIT=4; write cmd 8'h00, addr 15'h1234, data 32'hDEADBEEF -> line decodes bytes 00 12 34 DE AD BE EF. o_busy high for 280 cycles. o_done pulses once at cycle 281 after the accept edge.
2. Read cmd 8'h01, addr 15'h7FFF, data 32'hFFFFFFFF -> bytes 01 7F FF only. Bit 15 of the address word is 0. 120 busy cycles, then o_done.
3. Illegal cmd 8'h05 with i_start -> o_error=1 for one cycle. o_serial stays 1 and o_busy stays 0 for 200 cycles. A following legal start is then sent correctly.
4. Second i_start pulse (different data) mid-frame, plus inputs changed after accept -> the original frame is transmitted unchanged. No second frame follows and o_done pulses once.
5. reset asserted during DATA bit 3 of byte 2 -> next cycle o_serial=1, o_busy=0, and no o_done. A subsequent write frame is bit-exact.
6. Back-to-back: i_start held high continuously with a legal read -> consecutive frames separated by exactly 2 idle-high cycles (DONE + IDLE accept cycle). Each frame decodes correctly.

Source files
------------

// File: rtl/command_encoder_tx.sv
// command_encoder_tx: serialises one {command, address, data} request as a
// framed 8N1 UART byte stream for the FPGA-side command decoder.
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high
//   i_start    : frame request, sampled only while idle
//   i_command  : command code (CMD_WRITE / CMD_READ)
//   i_address  : 15-bit word address
//   i_data     : 32-bit write data (unused for reads)
//   o_serial   : UART TX line, idle high
//   o_busy     : frame in progress
//   o_done     : one-cycle pulse after the last stop bit
//   o_error    : one-cycle pulse on a start with an illegal command
module command_encoder_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  CMD_WRITE    = 8'h00,
  parameter logic [7:0]  CMD_READ     = 8'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [7:0]  i_command,
  input  logic [14:0] i_address,
  input  logic [31:0] i_data,
  output logic        o_serial,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BUF_W   = 56;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0]    byte_q, byte_d;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic                serial_d, busy_d, done_d, error_d;
  logic                bit_end_c;
  logic [BYTE_W-1:0]   cur_byte_c;

  assign bit_end_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      buf_q    <= '0;
      o_serial <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      buf_q    <= buf_d;
      o_serial <= serial_d;
      o_busy   <= busy_d;
      o_done   <= done_d;
      o_error  <= error_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they
  // line up with the state register.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    buf_d      = buf_q;
    error_d    = 1'b0;
    serial_d   = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    cur_byte_c = '0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_command == CMD_WRITE || i_command == CMD_READ) begin
            // Current byte always lives in the top 8 bits of the buffer
            buf_d   = {i_command, 1'b0, i_address, i_data};
            byte_d  = (i_command == CMD_WRITE) ? CNT_W'(7) : CNT_W'(3);
            baud_d  = '0;
            bit_d   = '0;
            state_d = START;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      START: begin
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == CNT_W'(7)) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          byte_d = byte_q - CNT_W'(1);
          if (byte_q == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            buf_d   = {buf_q[BUF_W-BYTE_W-1:0], BYTE_W'(0)};
            bit_d   = '0;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cur_byte_c = buf_d[BUF_W-1 -: BYTE_W];
    case (state_d)
      START: begin
        serial_d = 1'b0;
        busy_d   = 1'b1;
      end
      DATA: begin
        serial_d = cur_byte_c[bit_d];
        busy_d   = 1'b1;
      end
      STOP: begin
        busy_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        serial_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_command_encoder_tx.sv
// Directed bench for command_encoder_tx with CLKS_PER_BIT=4 (40 cycles/byte).
module tb_command_encoder_tx;

  localparam int CPB  = 4;
  localparam int BYTC = CPB * 10;
  localparam int MAXC = 400;

  logic        clock;
  logic        reset;
  logic        i_start;
  logic [7:0]  i_command;
  logic [14:0] i_address;
  logic [31:0] i_data;
  logic        o_serial;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  int errors;
  int checks;

  logic ser_s [0:MAXC];
  logic bsy_s [0:MAXC];
  logic dne_s [0:MAXC];
  logic err_s [0:MAXC];

  command_encoder_tx #(
    .CLKS_PER_BIT(CPB),
    .CMD_WRITE   (8'h00),
    .CMD_READ    (8'h01)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .i_start  (i_start),
    .i_command(i_command),
    .i_address(i_address),
    .i_data   (i_data),
    .o_serial (o_serial),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_error  (o_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record n cycles after an accept edge (sample k = mid of cycle k).
  // Unless start is held, inputs are scrambled right after the accept edge.
  task automatic capture(input int n, input bit hold_start, input bit disturb);
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      if (c == 1 && !hold_start) begin
        i_start   = 1'b0;
        i_command = i_command ^ 8'h01;
        i_address = ~i_address;
        i_data    = ~i_data;
      end
      if (disturb && c == 50) begin
        i_start   = 1'b1;
        i_command = 8'h01;
        i_address = 15'h0F0F;
        i_data    = 32'h12345678;
      end
      if (disturb && c == 51) i_start = 1'b0;
      ser_s[c] = o_serial;
      bsy_s[c] = o_busy;
      dne_s[c] = o_done;
      err_s[c] = o_error;
    end
  endtask

  // Check one frame whose first start-bit cycle is off+1; exp holds bytes MSB first.
  task automatic check_frame(input string tag, input int off, input int nb, input logic [55:0] exp);
    logic [9:0] word;
    logic [7:0] eb;
    int busy_n;
    for (int b = 0; b < nb; b++) begin
      eb = exp[55 - 8*b -: 8];
      for (int p = 0; p < 10; p++) word[p] = ser_s[off + 1 + b*BYTC + p*CPB + CPB/2];
      check($sformatf("%s byte%0d", tag, b), 64'(word), 64'({1'b1, eb, 1'b0}));
    end
    busy_n = 0;
    for (int c = off + 1; c <= off + nb*BYTC; c++) if (bsy_s[c] === 1'b1) busy_n++;
    check($sformatf("%s busy_cycles", tag), 64'(busy_n), 64'(nb*BYTC));
    check($sformatf("%s done_pulse", tag),
          64'({dne_s[off + nb*BYTC], dne_s[off + nb*BYTC + 1], bsy_s[off + nb*BYTC + 1]}),
          64'(3'b010));
  endtask

  // Accept one frame, check it, then check the tail stays idle.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [14:0] addr,
                           input logic [31:0] data, input int nb, input logic [55:0] exp,
                           input bit disturb);
    int n;
    int bad;
    n = nb*BYTC + 20;
    i_command = cmd;
    i_address = addr;
    i_data    = data;
    i_start   = 1'b1;
    @(posedge clock);
    capture(n, 1'b0, disturb);
    check_frame(tag, 0, nb, exp);
    bad = 0;
    for (int c = nb*BYTC + 2; c <= n; c++)
      if (bsy_s[c] !== 1'b0 || dne_s[c] !== 1'b0 || ser_s[c] !== 1'b1) bad++;
    for (int c = 1; c <= n; c++) if (err_s[c] !== 1'b0) bad++;
    check($sformatf("%s tail_idle", tag), 64'(bad), 64'(0));
  endtask

  initial begin
    int bad;
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    i_start   = 1'b0;
    i_command = 8'h00;
    i_address = '0;
    i_data    = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset serial", 64'(o_serial), 64'(1));
    check("reset busy",   64'(o_busy),   64'(0));
    check("reset done",   64'(o_done),   64'(0));
    check("reset error",  64'(o_error),  64'(0));
    repeat (2) @(negedge clock);

    // 1: write frame
    run_frame("t1_write", 8'h00, 15'h1234, 32'hDEADBEEF, 7, 56'h00_12_34_DE_AD_BE_EF, 1'b0);

    // 2: read frame, address bit 15 forced to 0, data ignored
    run_frame("t2_read", 8'h01, 15'h7FFF, 32'hFFFFFFFF, 3, 56'h01_7F_FF_00_00_00_00, 1'b0);

    // 3: illegal command
    i_command = 8'h05;
    i_address = 15'h0001;
    i_start   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    i_start = 1'b0;
    check("t3 error_pulse", 64'({o_error, o_busy, o_serial}), 64'(3'b101));
    @(negedge clock);
    check("t3 error_clear", 64'(o_error), 64'(0));
    bad = 0;
    for (int c = 0; c < 198; c++) begin
      @(negedge clock);
      if (o_serial !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
    end
    check("t3 idle_200", 64'(bad), 64'(0));
    run_frame("t3_after", 8'h00, 15'h0A5C, 32'h01234567, 7, 56'h00_0A_5C_01_23_45_67, 1'b0);

    // 4: restart request and input changes mid-frame are ignored
    run_frame("t4_ignore", 8'h00, 15'h4321, 32'hCAFEF00D, 7, 56'h00_43_21_CA_FE_F0_0D, 1'b1);

    // 5: reset during data bit 3 of the second byte
    i_command = 8'h00;
    i_address = 15'h1234;
    i_data    = 32'h89ABCDEF;
    i_start   = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 58; c++) begin
      @(negedge clock);
      if (c == 1) i_start = 1'b0;
    end
    check("t5 mid_frame", 64'({o_busy, o_serial}), 64'(2'b10));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5 reset_out", 64'({o_serial, o_busy, o_done}), 64'(3'b100));
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (o_serial !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
    end
    check("t5 quiet", 64'(bad), 64'(0));
    run_frame("t5_after", 8'h00, 15'h5A5A, 32'hA5A55A5A, 7, 56'h00_5A_5A_A5_A5_5A_5A, 1'b0);

    // 6: i_start held high -> frames back-to-back with a 2-cycle idle gap
    i_command = 8'h01;
    i_address = 15'h2B3C;
    i_data    = 32'h0;
    i_start   = 1'b1;
    @(posedge clock);
    capture(250, 1'b1, 1'b0);
    check_frame("t6_f0", 0,   3, 56'h01_2B_3C_00_00_00_00);
    check_frame("t6_f1", 122, 3, 56'h01_2B_3C_00_00_00_00);
    check("t6 gap", 64'({ser_s[121], bsy_s[121], ser_s[122], bsy_s[122], ser_s[123], bsy_s[123]}),
          64'(6'b101001));
    i_start = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
